// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb -- Y86-64 register file with per-register pending-write
// scoreboard.
//
// Purpose:
//   Two combinational read ports (srcA/srcB) feed decode. Two write-back ports
//   (E and M) commit results. Each register keeps a small counter of
//   in-flight writes. Decode stalls when it reads a register that still has a
//   write outstanding. Issue is back-pressured when a counter would saturate.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   srcA/srcB -> valA/valB combinational reads; RNONE or out-of-range reads 0
//   stall                 a read source has an outstanding write
//   iss_valid/iss_ready   issue handshake; iss_dstE/iss_dstM name the
//                         destinations that are counted at issue
//   wbE_valid/dstE/valE   E write-back
//   wbM_valid/dstM/valM   M write-back (wins over E on the same register)
//   wb_err                sticky: write-back seen while the counter was 0
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a read that hits an active write-back
//                      returns the incoming data, and a counter of 1 that is
//                      being retired this cycle does not stall.

// One register plus its pending-write counter.
module y86_rf_entry #(
  parameter int                DATA_W  = 64,
  parameter int                PEND_W  = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        inc,     // issue slots naming this register
  input  logic              inc_en,  // issue is accepted this cycle
  input  logic [1:0]        dec,     // write-backs naming this register
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              busy,    // counter nonzero as seen by decode
  output logic              ovf,     // accepting inc would saturate
  output logic              err      // write-back while counter is 0
);
  localparam logic [PEND_W:0] MAX_X = {1'b0, {PEND_W{1'b1}}};

  logic [DATA_W-1:0] data_q, data_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W:0]   cnt_x, dec_x, sat_x, sum_x;

  always_comb begin
    cnt_x  = (PEND_W+1)'(pend_q);
    dec_x  = (PEND_W+1)'(dec);
    // Retirements are applied first and floored at zero, then new issues.
    sat_x  = (cnt_x >= dec_x) ? (cnt_x - dec_x) : '0;
    sum_x  = sat_x + (PEND_W+1)'(inc);
    ovf    = (sum_x > MAX_X);
    pend_d = inc_en ? sum_x[PEND_W-1:0] : sat_x[PEND_W-1:0];
    err    = (dec != 2'd0) && (pend_q == '0);
    data_d = we ? wdata : data_q;
`ifdef REGFILE_BYPASS_EN
    busy   = (sat_x != '0);
`else
    busy   = (pend_q != '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
      pend_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign data = data_q;
endmodule

module y86_regfile_sb #(
  parameter int                DATA_W   = 64,
  parameter int                NUM_REGS = 15,
  parameter logic [3:0]        RNONE    = 4'hF,
  parameter int                RSP_IDX  = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter int                PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              stall,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [3:0]        iss_dstE,
  input  logic [3:0]        iss_dstM,
  input  logic              wbE_valid,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic              wbM_valid,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              wb_err
);
  if (NUM_REGS > 15 || NUM_REGS < 1) begin : g_bad_cfg
    $error("y86_regfile_sb: NUM_REGS must be 1..15");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] rf_data;
  logic [NUM_REGS-1:0]             rf_busy, rf_ovf, rf_err;
  logic                            iss_fire;
  logic                            wb_err_q, wb_err_d;

  // Per-register decode of issue and write-back addresses. Comparing against
  // the loop index only ever matches valid registers; the RNONE term covers a
  // configuration where RNONE falls inside 0..NUM_REGS-1.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic       iss_e, iss_m, wb_e, wb_m;
    logic [1:0] inc, dec;

    always_comb begin
      iss_e = (iss_dstE == 4'(g)) && (iss_dstE != RNONE);
      iss_m = (iss_dstM == 4'(g)) && (iss_dstM != RNONE);
      wb_e  = wbE_valid && (dstE == 4'(g)) && (dstE != RNONE);
      wb_m  = wbM_valid && (dstM == 4'(g)) && (dstM != RNONE);
      inc   = {1'b0, iss_e} + {1'b0, iss_m};
      dec   = {1'b0, wb_e} + {1'b0, wb_m};
    end

    y86_rf_entry #(
      .DATA_W (DATA_W),
      .PEND_W (PEND_W),
      .RST_VAL((g == RSP_IDX) ? RSP_INIT : '0)
    ) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc),
      .inc_en(iss_fire),
      .dec   (dec),
      .we    (wb_e | wb_m),
      .wdata (wb_m ? valM : valE),   // M wins a same-register collision
      .data  (rf_data[g]),
      .busy  (rf_busy[g]),
      .ovf   (rf_ovf[g]),
      .err   (rf_err[g])
    );
  end

  // Read ports: index 0 is A, index 1 is B.
  logic [1:0][3:0]        src;
  logic [1:0][DATA_W-1:0] rdv;
  logic [1:0]             src_stall;

  assign src = {srcB, srcA};

  always_comb begin
    rdv       = '0;
    src_stall = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (src[p] == 4'(i) && src[p] != RNONE) begin
          rdv[p]       = rf_data[i];
          src_stall[p] = rf_busy[i];
`ifdef REGFILE_BYPASS_EN
          if (wbE_valid && dstE == src[p]) rdv[p] = valE;
          if (wbM_valid && dstM == src[p]) rdv[p] = valM;
`endif
        end
      end
    end
  end

  assign valA = rdv[0];
  assign valB = rdv[1];

  // During reset the counters are already clear; the explicit gating pins the
  // handshake outputs regardless of configuration.
  always_comb begin
    stall     = rst_n && (|src_stall);
    iss_ready = !rst_n || !(|rf_ovf);
    iss_fire  = rst_n && iss_valid && !(|rf_ovf);
    wb_err_d  = wb_err_q | (|rf_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_err_q <= 1'b0;
    else        wb_err_q <= wb_err_d;
  end

  assign wb_err = wb_err_q;
endmodule

// File: doc/y86_regfile_sb.md
Name: y86_regfile_sb

Overview:
- Parametrised successor to the Y86-64 decode/writeback register file for the pipelined core.
- Two combinational read ports (srcA/srcB) and two write-back ports (E and M).
- Per-register pending-write scoreboard raises a stall when decode reads a register with an in-flight write; issue is back-pressured when a scoreboard counter saturates.
- Sits between the fetch/decode stage and the execute stage, with write-back from the E and M stages.

Parameters:
- DATA_W, 64, register data width.
- NUM_REGS, 15, implemented registers, indices 0..NUM_REGS-1; must be <= 15.
- RNONE, 4'hF, "no register" encoding; never read, never written.
- RSP_IDX, 4, stack-pointer index.
- RSP_INIT, 64'h0, reset value of register RSP_IDX; all other registers reset to 0.
- PEND_W, 2, width of each per-register pending counter (max 2^PEND_W-1 in flight).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- srcA  in  4  read address A.
- srcB  in  4  read address B.
- valA  out  DATA_W  read data A.
- valB  out  DATA_W  read data B.
- stall  out  1  srcA or srcB has a pending write not satisfied this cycle.
- iss_valid  in  1  decode issues an instruction to execute.
- iss_ready  out  1  issue accepted this cycle.
- iss_dstE  in  4  destination of E result at issue (RNONE = none).
- iss_dstM  in  4  destination of M result at issue (RNONE = none).
- wbE_valid  in  1  E write-back strobe.
- dstE  in  4  E write address.
- valE  in  DATA_W  E write data.
- wbM_valid  in  1  M write-back strobe.
- dstM  in  4  M write address.
- valM  in  DATA_W  M write data.
- wb_err  out  1  sticky: write-back to a register whose counter was 0.

Behaviour:
- Reset (rst_n low, immediate): all registers 0 except reg[RSP_IDX] = RSP_INIT; all pending counters 0; wb_err 0. Reset mid-operation discards all in-flight state.
- Outputs while in reset: stall 0, iss_ready 1.
- Reads are combinational. Address == RNONE or >= NUM_REGS returns 0.
- Writes commit on rising clk when the strobe is high and the address is valid. An invalid address (RNONE or >= NUM_REGS) is ignored: no write, no counter change.
- dstE == dstM with both strobes high: valM is written (popq %rsp semantics); that counter decrements by 2, floored at 0.
- Pending counter per register:
  - increment on accepted issue naming it (as iss_dstE or iss_dstM);
  - decrement on each write-back naming it;
  - same-cycle increment and decrement: net value applied;
  - iss_dstE == iss_dstM: count 2.
- iss_ready is 0 when any named destination counter would exceed 2^PEND_W-1. An issue with iss_ready low changes no state.
- Write-back with counter 0: data is still written, counter stays 0, wb_err set until reset.
- stall = (srcA valid && pendA != 0) || (srcB valid && pendB != 0), evaluated after crediting same-cycle write-backs per the optional feature. An address of RNONE never stalls.
- Latency: with the bypass feature off, a written value is visible on valA/valB in the cycle after the clk edge.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches an active write-back this cycle returns the incoming data (valM takes priority over valE). A counter of 1 being decremented this cycle does not stall.
- Undefined: reads return stored values only; stall considers the pre-update counter.

Test Plan:
- Reset with RSP_INIT=64'h100 -> valA=64'h100 for srcA=4, 0 for srcA=0..3, 5..14; srcA=15 -> 0, stall 0.
- Write-back wbE_valid dstE=3 valE=64'hDEAD -> next cycle srcA=3 gives 64'hDEAD; dstE=15 write leaves all registers unchanged.
- Issue iss_dstE=2, then read srcB=2 -> stall 1; wbE dstE=2 -> stall 0 next cycle (same cycle if REGFILE_BYPASS_EN, with valB = valE).
- Both ports write reg 4: valE=64'h10, valM=64'h20 -> reg4 = 64'h20; counter for reg 4, previously 2, reaches 0.
- Three issues to reg 7 with PEND_W=2 -> third accepted (count 3); fourth sees iss_ready 0 and the count stays 3.
- wbM dstM=5 with counter 0 -> reg5 written, wb_err 1 and stays 1; rst_n pulsed low mid-run -> all counters 0, wb_err 0 asynchronously.
